// File: rtl/alu_mc_ctrl_pkg.sv
// alu_mc_ctrl_pkg
//   Shared definitions for the multi-cycle ALU controller:
//   - alu_control code constants (integer and floating-point groups)
//   - controller state enum
//   - FP code to one-hot bit-index map function
package alu_mc_ctrl_pkg;

  // Integer op codes (alu_control[4] = 0)
  localparam logic [4:0] OP_SLL  = 5'h00;
  localparam logic [4:0] OP_SRL  = 5'h01;
  localparam logic [4:0] OP_ADD  = 5'h02;
  localparam logic [4:0] OP_SRA  = 5'h03;
  localparam logic [4:0] OP_AND  = 5'h04;
  localparam logic [4:0] OP_OR   = 5'h05;
  localparam logic [4:0] OP_SUB  = 5'h06;
  localparam logic [4:0] OP_LINK = 5'h07;
  localparam logic [4:0] OP_BEQ  = 5'h08;
  localparam logic [4:0] OP_BGEU = 5'h09;

  // FP op codes (alu_control[4] = 1), named by the fpu_op bit they drive
  localparam logic [4:0] FP_CODE_B0 = 5'h10;
  localparam logic [4:0] FP_CODE_B1 = 5'h11;
  localparam logic [4:0] FP_CODE_B2 = 5'h12;
  localparam logic [4:0] FP_CODE_B3 = 5'h13;
  localparam logic [4:0] FP_CODE_B4 = 5'h1B;
  localparam logic [4:0] FP_CODE_B5 = 5'h16;
  localparam logic [4:0] FP_CODE_B6 = 5'h17;
  localparam logic [4:0] FP_CODE_B7 = 5'h15;
  localparam logic [4:0] FP_CODE_B8 = 5'h19;
  localparam logic [4:0] FP_CODE_B9 = 5'h18;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_FPU = 2'd1,
    HOLD     = 2'd2
  } alu_state_e;

  // Result of looking up an FP code: hit=0 means the code has no FPU op
  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } fp_map_t;

  function automatic fp_map_t fp_map(input logic [4:0] code);
    fp_map_t m;
    m.hit = 1'b1;
    m.idx = 4'd0;
    case (code)
      FP_CODE_B0: m.idx = 4'd0;
      FP_CODE_B1: m.idx = 4'd1;
      FP_CODE_B2: m.idx = 4'd2;
      FP_CODE_B3: m.idx = 4'd3;
      FP_CODE_B4: m.idx = 4'd4;
      FP_CODE_B5: m.idx = 4'd5;
      FP_CODE_B6: m.idx = 4'd6;
      FP_CODE_B7: m.idx = 4'd7;
      FP_CODE_B8: m.idx = 4'd8;
      FP_CODE_B9: m.idx = 4'd9;
      default: begin
        m.hit = 1'b0;
        m.idx = 4'd0;
      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_mc_ctrl_int_core.sv
// alu_int_core
//   Purely combinational integer datapath: shifts, logic, add/sub,
//   link (pc+4) and branch compares.
//   Ports:
//     op     in  5      alu_control code (integer group)
//     a, b   in  WIDTH  operands; shift amount is the low $clog2(WIDTH) bits of b
//     pc     in  WIDTH  instruction PC for the link op
//     result out WIDTH  op result (0 for branches and unused codes)
//     taken  out 1      branch/link taken flag
module alu_int_core
  import alu_mc_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] result,
  output logic             taken
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt_s;

  assign shamt_s = b[SHW-1:0];

  // Integer op decode and evaluation
  always_comb begin
    result = '0;
    taken  = 1'b0;
    case (op)
      OP_SLL:  result = a << shamt_s;
      OP_SRL:  result = a >> shamt_s;
      OP_SRA:  result = $unsigned($signed(a) >>> shamt_s);
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_LINK: begin
        result = pc + WIDTH'(32'd4);
        taken  = 1'b1;
      end
      OP_BEQ:  taken = (a == b);
      OP_BGEU: taken = (a >= b);
      default: begin
        result = '0;
        taken  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_mc_ctrl.sv
// alu_mc_ctrl
//   ALU controller: integer ops complete with one-cycle latency, FP ops are
//   launched to an external FPU and awaited with a timeout. Results are held
//   under a valid/ready handshake; a new op may be accepted in the same cycle
//   the held result is consumed.
//   Ports:
//     clk, rstn              clock, synchronous active-low reset
//     in_valid/in_ready      op handshake; alu_control, pc_ex, src_a, src_b
//     out_valid/out_ready    result handshake; result, branch_taken, err
//     fpu_req/fpu_op/a/b     one-cycle FPU launch with one-hot opcode
//     fpu_done/fpu_y         one-cycle FPU completion and its result
module alu_mc_ctrl
  import alu_mc_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int FPU_TIMEOUT = 64,
  parameter int FPU_OPS     = 10
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         alu_control,
  input  logic [WIDTH-1:0]   pc_ex,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               branch_taken,
  output logic               err,
  output logic               fpu_req,
  output logic [FPU_OPS-1:0] fpu_op,
  output logic [WIDTH-1:0]   fpu_a,
  output logic [WIDTH-1:0]   fpu_b,
  input  logic               fpu_done,
  input  logic [WIDTH-1:0]   fpu_y
);

  localparam int               CNT_W    = $clog2(FPU_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FPU_TIMEOUT - 1);

  alu_state_e         state_r, state_nx;
  logic [CNT_W-1:0]   cnt_r, cnt_nx;
  logic               out_valid_r, out_valid_nx;
  logic [WIDTH-1:0]   result_r, result_nx;
  logic               taken_r, taken_nx;
  logic               err_r, err_nx;
  logic               fpu_req_r, fpu_req_nx;
  logic [FPU_OPS-1:0] fpu_op_r, fpu_op_nx;
  logic [WIDTH-1:0]   fpu_a_r, fpu_a_nx;
  logic [WIDTH-1:0]   fpu_b_r, fpu_b_nx;

  logic [WIDTH-1:0]   int_result_s;
  logic               int_taken_s;
  fp_map_t            fp_map_s;
  logic               fp_hit_s;
  logic [FPU_OPS-1:0] fp_onehot_s;
  logic               accept_s;

  alu_int_core #(
    .WIDTH (WIDTH)
  ) u_int_core (
    .op     (alu_control),
    .a      (src_a),
    .b      (src_b),
    .pc     (pc_ex),
    .result (int_result_s),
    .taken  (int_taken_s)
  );

  // FP code lookup; an index beyond the FPU opcode width counts as unmapped
  always_comb begin
    fp_map_s    = fp_map(alu_control);
    fp_onehot_s = '0;
    if (fp_map_s.hit && (int'(fp_map_s.idx) < FPU_OPS)) begin
      fp_hit_s                  = 1'b1;
      fp_onehot_s[fp_map_s.idx] = 1'b1;
    end else begin
      fp_hit_s = 1'b0;
    end
  end

  // Input readiness: HOLD frees up only when its result is being consumed
  always_comb begin
    case (state_r)
      IDLE:     in_ready = 1'b1;
      HOLD:     in_ready = out_ready;
      WAIT_FPU: in_ready = 1'b0;
      default:  in_ready = 1'b0;
    endcase
  end

  assign accept_s = in_valid & in_ready;

  // Next-state and next-output computation
  always_comb begin
    state_nx     = state_r;
    cnt_nx       = cnt_r;
    out_valid_nx = out_valid_r;
    result_nx    = result_r;
    taken_nx     = taken_r;
    err_nx       = err_r;
    fpu_req_nx   = 1'b0;
    fpu_op_nx    = fpu_op_r;
    fpu_a_nx     = fpu_a_r;
    fpu_b_nx     = fpu_b_r;

    if (accept_s) begin
      // Acceptance happens from IDLE or from HOLD while the result drains
      if (!alu_control[4]) begin
        result_nx    = int_result_s;
        taken_nx     = int_taken_s;
        err_nx       = 1'b0;
        out_valid_nx = 1'b1;
        state_nx     = HOLD;
      end else if (fp_hit_s) begin
        fpu_req_nx   = 1'b1;
        fpu_op_nx    = fp_onehot_s;
        fpu_a_nx     = src_a;
        fpu_b_nx     = src_b;
        cnt_nx       = '0;
        out_valid_nx = 1'b0;
        state_nx     = WAIT_FPU;
      end else begin
        result_nx    = '0;
        taken_nx     = 1'b0;
        err_nx       = 1'b1;
        out_valid_nx = 1'b1;
        state_nx     = HOLD;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_nx = IDLE;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_nx = 1'b0;
            state_nx     = IDLE;
          end else begin
            state_nx = HOLD;
          end
        end
        WAIT_FPU: begin
          // fpu_done is honoured even in the cycle fpu_req is still high
          if (fpu_done) begin
            result_nx    = fpu_y;
            taken_nx     = 1'b0;
            err_nx       = 1'b0;
            out_valid_nx = 1'b1;
            cnt_nx       = '0;
            state_nx     = HOLD;
          end else if (cnt_r == CNT_LAST) begin
            result_nx    = '0;
            taken_nx     = 1'b0;
            err_nx       = 1'b1;
            out_valid_nx = 1'b1;
            cnt_nx       = '0;
            state_nx     = HOLD;
          end else begin
            cnt_nx = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          out_valid_nx = 1'b0;
          state_nx     = IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      taken_r     <= 1'b0;
      err_r       <= 1'b0;
      fpu_req_r   <= 1'b0;
      fpu_op_r    <= '0;
      fpu_a_r     <= '0;
      fpu_b_r     <= '0;
    end else begin
      state_r     <= state_nx;
      cnt_r       <= cnt_nx;
      out_valid_r <= out_valid_nx;
      result_r    <= result_nx;
      taken_r     <= taken_nx;
      err_r       <= err_nx;
      fpu_req_r   <= fpu_req_nx;
      fpu_op_r    <= fpu_op_nx;
      fpu_a_r     <= fpu_a_nx;
      fpu_b_r     <= fpu_b_nx;
    end
  end

  assign out_valid    = out_valid_r;
  assign result       = result_r;
  assign branch_taken = taken_r;
  assign err          = err_r;
  assign fpu_req      = fpu_req_r;
  assign fpu_op       = fpu_op_r;
  assign fpu_a        = fpu_a_r;
  assign fpu_b        = fpu_b_r;

endmodule

// File: tb/tb_alu_mc_ctrl.sv
// tb_alu_mc_ctrl
//   Self-checking bench: transaction-level reference model updated on each
//   clock, one compare process on the falling edge, directed literal cases,
//   then randomized traffic including random resets and stray fpu_done.
module tb_alu_mc_ctrl;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rstn, in_valid, out_ready, fpu_done;
  logic [4:0]  alu_control;
  logic [31:0] pc_ex, src_a, src_b, fpu_y;
  logic        in_ready, out_valid, branch_taken, err, fpu_req;
  logic [31:0] result, fpu_a, fpu_b;
  logic [9:0]  fpu_op;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // reference model state (transaction view)
  bit          m_ov, m_tk, m_err, m_req, m_wait;
  logic [31:0] m_res, m_fa, m_fb;
  logic [9:0]  m_fop;
  int          m_wcnt;

  logic [4:0] fp_codes [10] = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h1B,
                                5'h16, 5'h17, 5'h15, 5'h19, 5'h18};

  alu_mc_ctrl #(.WIDTH(32), .FPU_TIMEOUT(TO), .FPU_OPS(10)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .pc_ex(pc_ex), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .branch_taken(branch_taken), .err(err), .fpu_req(fpu_req),
    .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_done(fpu_done),
    .fpu_y(fpu_y)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fp_index(input logic [4:0] c);
    for (int i = 0; i < 10; i++)
      if (fp_codes[i] == c) return i;
    return -1;
  endfunction

  // returns {taken, result}
  function automatic logic [32:0] ref_int(input logic [4:0] code, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] pc);
    logic [63:0] wide;
    logic [31:0] r;
    logic        t;
    int          sh;
    sh = int'(b % 32);
    r  = 32'h0;
    t  = 1'b0;
    case (code)
      5'd0: r = a << sh;
      5'd1: r = a >> sh;
      5'd3: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      5'd4: r = a & b;
      5'd5: r = a | b;
      5'd2: begin wide = 64'(a) + 64'(b); r = wide[31:0]; end
      5'd6: begin wide = 64'h1_0000_0000 + 64'(a) - 64'(b); r = wide[31:0]; end
      5'd7: begin wide = 64'(pc) + 64'd4; r = wide[31:0]; t = 1'b1; end
      5'd8: t = (a == b);
      5'd9: t = (a >= b);
      default: r = 32'h0;
    endcase
    return {t, r};
  endfunction

  // reference model: one transaction step per clock
  always @(posedge clk) begin
    automatic bit          acc;
    automatic int          idx;
    automatic logic [32:0] ir;
    if (!rstn) begin
      m_ov <= 1'b0; m_tk <= 1'b0; m_err <= 1'b0; m_req <= 1'b0; m_wait <= 1'b0;
      m_res <= 32'h0; m_fa <= 32'h0; m_fb <= 32'h0; m_fop <= 10'h0; m_wcnt <= 0;
    end else begin
      acc = in_valid && !m_wait && (!m_ov || out_ready);
      m_req <= 1'b0;
      if (m_ov && out_ready) m_ov <= 1'b0;
      if (m_wait) begin
        if (fpu_done) begin
          m_wait <= 1'b0; m_ov <= 1'b1; m_res <= fpu_y; m_tk <= 1'b0; m_err <= 1'b0;
        end else if (m_wcnt + 1 == TO) begin
          m_wait <= 1'b0; m_ov <= 1'b1; m_res <= 32'h0; m_tk <= 1'b0; m_err <= 1'b1;
        end else begin
          m_wcnt <= m_wcnt + 1;
        end
      end
      if (acc) begin
        idx = fp_index(alu_control);
        if (!alu_control[4]) begin
          ir = ref_int(alu_control, src_a, src_b, pc_ex);
          m_res <= ir[31:0]; m_tk <= ir[32]; m_err <= 1'b0; m_ov <= 1'b1;
        end else if (idx >= 0) begin
          m_wait <= 1'b1; m_wcnt <= 0; m_req <= 1'b1;
          m_fop <= 10'd1 << idx; m_fa <= src_a; m_fb <= src_b; m_ov <= 1'b0;
        end else begin
          m_res <= 32'h0; m_tk <= 1'b0; m_err <= 1'b1; m_ov <= 1'b1;
        end
      end
    end
  end

  // compare DUT against the model mid-cycle
  always @(negedge clk) begin
    if (check_en) begin
      chk1("in_ready", in_ready, !m_wait && (!m_ov || out_ready));
      chk1("out_valid", out_valid, m_ov);
      chk1("fpu_req", fpu_req, m_req);
      if (m_ov) begin
        chk32("result", result, m_res);
        chk1("branch_taken", branch_taken, m_tk);
        chk1("err", err, m_err);
      end
      if (m_req) begin
        chk32("fpu_op", 32'(fpu_op), 32'(m_fop));
        chk32("fpu_a", fpu_a, m_fa);
        chk32("fpu_b", fpu_b, m_fb);
      end
    end
  end

  task automatic issue(input logic [4:0] code, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc);
    @(negedge clk); #1;
    in_valid = 1'b1; alu_control = code; src_a = a; src_b = b; pc_ex = pc;
    for (int n = 0; n < 200 && !in_ready; n++) begin
      @(negedge clk); #1;
    end
    chk1("issue_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; src_a = $urandom; src_b = $urandom;
  endtask

  task automatic consume();
    @(negedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic int_case(input string name, input logic [4:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] pc,
                          input logic [31:0] exp_res, input logic exp_tk);
    issue(code, a, b, pc);
    @(negedge clk);
    chk1({name, "_valid"}, out_valid, 1'b1);
    chk32({name, "_result"}, result, exp_res);
    chk1({name, "_taken"}, branch_taken, exp_tk);
    chk1({name, "_err"}, err, 1'b0);
    consume();
  endtask

  task automatic chk_all_zero(input string name);
    chk1({name, "_out_valid"}, out_valid, 1'b0);
    chk32({name, "_result"}, result, 32'h0);
    chk1({name, "_taken"}, branch_taken, 1'b0);
    chk1({name, "_err"}, err, 1'b0);
    chk1({name, "_fpu_req"}, fpu_req, 1'b0);
    chk32({name, "_fpu_op"}, 32'(fpu_op), 32'h0);
    chk32({name, "_fpu_a"}, fpu_a, 32'h0);
    chk32({name, "_fpu_b"}, fpu_b, 32'h0);
    chk1({name, "_in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    int seen;
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; fpu_done = 1'b0;
    alu_control = 5'h0; pc_ex = 32'h0; src_a = 32'h0; src_b = 32'h0; fpu_y = 32'h0;
    repeat (3) @(posedge clk);
    #1 check_en = 1'b1;
    @(negedge clk);
    chk_all_zero("reset");
    #1 rstn = 1'b1;

    // integer literal cases
    int_case("add_wrap", 5'd2, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b0);
    int_case("sll_mask", 5'd0, 32'h1, 32'h21, 32'h0, 32'h2, 1'b0);
    int_case("sra_neg", 5'd3, 32'h8000_0000, 32'h4, 32'h0, 32'hF800_0000, 1'b0);
    int_case("bgeu_lt", 5'd9, 32'd5, 32'd7, 32'h0, 32'h0, 1'b0);
    int_case("beq_eq", 5'd8, 32'd9, 32'd9, 32'h0, 32'h0, 1'b1);
    int_case("link", 5'd7, 32'h0, 32'h0, 32'h100, 32'h104, 1'b1);
    int_case("unused_code", 5'd12, 32'h55, 32'h66, 32'h0, 32'h0, 1'b0);

    // FP op, fpu_done three cycles after fpu_req
    issue(5'h12, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0);
    @(negedge clk);
    chk1("fp_req", fpu_req, 1'b1);
    chk32("fp_op", 32'(fpu_op), 32'h004);
    chk32("fp_a", fpu_a, 32'hAAAA_0001);
    chk1("fp_wait_ready0", in_ready, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk1("fp_wait_ready", in_ready, 1'b0);
      chk1("fp_wait_valid", out_valid, 1'b0);
      if (i == 3) begin
        #1 fpu_done = 1'b1; fpu_y = 32'h3F80_0000;
      end
    end
    @(posedge clk); #1 fpu_done = 1'b0;
    @(negedge clk);
    chk1("fp_done_valid", out_valid, 1'b1);
    chk32("fp_done_result", result, 32'h3F80_0000);
    chk1("fp_done_err", err, 1'b0);
    consume();

    // unmapped FP code
    issue(5'h14, 32'h1, 32'h2, 32'h0);
    @(negedge clk);
    chk1("fp_unmapped_req", fpu_req, 1'b0);
    chk1("fp_unmapped_err", err, 1'b1);
    chk32("fp_unmapped_result", result, 32'h0);
    consume();

    // timeout, then a late fpu_done
    issue(5'h10, 32'h7, 32'h8, 32'h0);
    seen = 0;
    for (int n = 1; n <= 100 && seen == 0; n++) begin
      @(negedge clk);
      if (out_valid) seen = n;
    end
    chk32("timeout_latency", 32'(seen), 32'(TO + 1));
    chk1("timeout_err", err, 1'b1);
    chk32("timeout_result", result, 32'h0);
    #1 fpu_done = 1'b1; fpu_y = 32'h1234_5678;
    @(posedge clk); #1 fpu_done = 1'b0;
    @(negedge clk);
    chk32("late_done_result", result, 32'h0);
    chk1("late_done_err", err, 1'b1);
    consume();

    // held result, then back-to-back SUB
    issue(5'd5, 32'hF0, 32'h0F, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk32("hold_result", result, 32'hFF);
      chk1("hold_valid", out_valid, 1'b1);
    end
    #1 out_ready = 1'b1; in_valid = 1'b1; alu_control = 5'd6; src_a = 32'd3; src_b = 32'd5;
    #1 chk1("b2b_ready", in_ready, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk1("b2b_valid", out_valid, 1'b1);
    chk32("b2b_result", result, 32'hFFFF_FFFE);
    consume();

    // reset during WAIT_FPU, stale fpu_done
    issue(5'h11, 32'h9, 32'h9, 32'h0);
    @(negedge clk); @(negedge clk);
    #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_reset");
    #1 fpu_done = 1'b1; fpu_y = 32'hDEAD_BEEF;
    @(posedge clk); #1 fpu_done = 1'b0;
    @(negedge clk);
    chk1("stale_done_valid", out_valid, 1'b0);
    int_case("after_reset", 5'd2, 32'd2, 32'd3, 32'h0, 32'd5, 1'b0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      rstn        = ($urandom_range(0, 299) != 0);
      in_valid    = 1'($urandom_range(0, 1));
      alu_control = ($urandom_range(0, 1) == 1) ? fp_codes[$urandom_range(0, 9)]
                                                : 5'($urandom_range(0, 31));
      src_a       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      src_b       = ($urandom_range(0, 3) == 0) ? src_a : $urandom;
      pc_ex       = $urandom;
      out_ready   = ($urandom_range(0, 2) != 0);
      fpu_done    = ($urandom_range(0, 3) == 0);
      fpu_y       = $urandom;
    end
    @(negedge clk); #1;
    rstn = 1'b1; in_valid = 1'b0; fpu_done = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mc_ctrl.md
ALU_MC_CTRL -- requirements
Module: alu_mc_ctrl

Interface
REQ-001 SHALL have parameters: WIDTH, default 32, datapath width; FPU_TIMEOUT, default 64, maximum cycles waiting on fpu_done; FPU_OPS, default 10, width of the one-hot FPU opcode.
REQ-002 SHALL have ports: clk in 1, clock; rstn in 1, reset (synchronous, active-low); in_valid in 1, operation offered; in_ready out 1, operation accepted when both high; alu_control in 5, op code; pc_ex in WIDTH, instruction PC; src_a in WIDTH, operand A; src_b in WIDTH, operand B.
REQ-003 SHALL have ports: out_valid out 1, result available; out_ready in 1, consumer accepts; result out WIDTH; branch_taken out 1; err out 1, timeout flag qualified by out_valid.
REQ-004 SHALL have FPU ports: fpu_req out 1, single-cycle launch pulse; fpu_op out FPU_OPS, one-hot opcode; fpu_a out WIDTH; fpu_b out WIDTH; fpu_done in 1, single-cycle completion pulse; fpu_y in WIDTH, FPU result.

Function
REQ-005 SHALL implement states IDLE, WAIT_FPU, HOLD.
REQ-006 in_ready SHALL be 1 in IDLE, 1 in HOLD when out_ready=1, and 0 in WAIT_FPU.
REQ-007 Integer ops (alu_control[4]=0) SHALL be accepted, computed, and registered in the acceptance cycle, then enter HOLD; out_valid=1 on the next cycle, giving 1-cycle latency.
REQ-008 Integer codes: 0 SLL; 1 SRL; 3 SRA; 4 AND; 5 OR; 2 ADD; 6 SUB; 7 link (pc_ex+4, branch_taken=1); 8 BEQ (taken iff a==b); 9 BGEU (taken iff a>=b unsigned); others give result 0, not taken.
REQ-009 Shift amount SHALL be src_b[$clog2(WIDTH)-1:0]; upper bits ignored.
REQ-010 ADD/SUB SHALL wrap modulo 2^WIDTH.
REQ-011 branch_taken SHALL be 0 for all codes other than 7, 8, and 9.
REQ-012 FP ops (alu_control[4]=1) SHALL be accepted, then fpu_req=1 for exactly the following cycle with fpu_op/fpu_a/fpu_b registered, then enter WAIT_FPU.
REQ-013 FP opcode map to fpu_op bit: 0x10->0, 0x11->1, 0x12->2, 0x13->3, 0x1B->4, 0x16->5, 0x17->6, 0x15->7, 0x19->8, 0x18->9.
REQ-014 An unmapped FP code SHALL NOT pulse fpu_req; it SHALL complete as an integer-style op with result 0 and err=1.
REQ-015 In WAIT_FPU, fpu_done=1 SHALL capture fpu_y into result, set branch_taken=0 and err=0, and enter HOLD.
REQ-016 fpu_done arriving in the same cycle as fpu_req SHALL be honoured.
REQ-017 fpu_done outside WAIT_FPU SHALL be ignored.
REQ-018 A wait counter SHALL run in WAIT_FPU; reaching FPU_TIMEOUT cycles without fpu_done SHALL enter HOLD with result 0 and err=1.
REQ-019 A late fpu_done after a timeout SHALL be ignored.
REQ-020 In HOLD, out_valid=1 and result/branch_taken/err SHALL stay stable until out_ready=1.
REQ-021 On out_ready=1 in HOLD, the block SHALL return to IDLE, or accept a new op in the same cycle if in_valid=1 (back-to-back, no bubble).
REQ-022 Operands SHALL NOT be sampled when in_valid=0; in_valid=1 with in_ready=0 SHALL leave all state unchanged.

Reset
REQ-023 rstn=0 at a clk edge SHALL force IDLE, wait counter 0, out_valid=0, result=0, branch_taken=0, err=0, fpu_req=0, fpu_op=0, fpu_a=0, and fpu_b=0.
REQ-024 A reset during WAIT_FPU or HOLD SHALL abandon the op; a subsequent fpu_done SHALL be ignored.

Structure
REQ-025 A shared package SHALL hold the alu_control code constants, the FP-to-one-hot map function, and the state enum.
REQ-026 The integer datapath SHALL be one combinational sub-module, alu_int_core (inputs: op, a, b, pc; outputs: result, taken), parametrised by WIDTH.

Verification
REQ-027 ADD 0xFFFFFFFF+1 -> result 0x00000000 one cycle after accept; SLL a=1, b=0x21 -> 0x00000002.
REQ-028 BGEU a=5, b=7 -> branch_taken=0; BEQ a=b=9 -> branch_taken=1; code 7 with pc_ex=0x100 -> result 0x104, taken=1.
REQ-029 FP code 0x12, fpu_done 3 cycles after fpu_req with fpu_y=0x3F800000 -> fpu_op=0x004, result 0x3F800000, err=0, in_ready=0 throughout the wait.
REQ-030 FP op with no fpu_done -> HOLD after 64 cycles, err=1, result 0; a late fpu_done is ignored.
REQ-031 out_ready held 0 for 5 cycles -> result stable; then out_ready=1 with in_valid=1 (SUB 3-5) -> 0xFFFFFFFE the next cycle, no bubble.
REQ-032 rstn=0 mid-WAIT_FPU -> IDLE with all outputs 0; a stale fpu_done is ignored and the next op completes normally.
